// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment definitions.
//   Segment bit order (bit 6 .. bit 0) is {a,b,c,d,e,f,g}, active-high.
//   Holds the 7-bit glyph constants for 0-F and blank (shared with the
//   encoder blocks) and the decode result structure.
package seg7_pkg;

  // Bit positions within a 7-bit segment word.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG7_BLANK = 7'b0000000;
  localparam logic [6:0] SEG7_0     = 7'b1111110;
  localparam logic [6:0] SEG7_1     = 7'b0110000;
  localparam logic [6:0] SEG7_2     = 7'b1101101;
  localparam logic [6:0] SEG7_3     = 7'b1111001;
  localparam logic [6:0] SEG7_4     = 7'b0110011;
  localparam logic [6:0] SEG7_5     = 7'b1011011;
  localparam logic [6:0] SEG7_6     = 7'b1011111;
  localparam logic [6:0] SEG7_7     = 7'b1110000;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1111011;
  localparam logic [6:0] SEG7_HA    = 7'b1110111;
  localparam logic [6:0] SEG7_HB    = 7'b0011111;
  localparam logic [6:0] SEG7_HC    = 7'b1001110;
  localparam logic [6:0] SEG7_HD    = 7'b0111101;
  localparam logic [6:0] SEG7_HE    = 7'b1001111;
  localparam logic [6:0] SEG7_HF    = 7'b1000111;

  // Result of decoding one segment word.
  typedef struct packed {
    logic       known;     // pattern maps to a digit
    logic       is_blank;  // all segments off
    logic [3:0] nibble;    // decoded value, 0 when not known
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment-word to nibble decoder.
//   Ports:
//     seg_i      [6:0]  segment word {a,b,c,d,e,f,g}, active-high
//     known_o           pattern is a recognised digit
//     is_blank_o        pattern is all segments off
//     nibble_o   [3:0]  decoded value (0 when not known)
//   Macro SEG7_DEC_HEX_EN: when defined, the A-F glyphs decode to 10-15;
//   otherwise they fall through as unrecognised.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       known_o,
  output logic       is_blank_o,
  output logic [3:0] nibble_o
);

  seg7_dec_t dec;

  always_comb begin
    dec = '0;
    case (seg_i)
      SEG7_BLANK: dec.is_blank = 1'b1;
      SEG7_0:     begin dec.known = 1'b1; dec.nibble = 4'h0; end
      SEG7_1:     begin dec.known = 1'b1; dec.nibble = 4'h1; end
      SEG7_2:     begin dec.known = 1'b1; dec.nibble = 4'h2; end
      SEG7_3:     begin dec.known = 1'b1; dec.nibble = 4'h3; end
      SEG7_4:     begin dec.known = 1'b1; dec.nibble = 4'h4; end
      SEG7_5:     begin dec.known = 1'b1; dec.nibble = 4'h5; end
      SEG7_6:     begin dec.known = 1'b1; dec.nibble = 4'h6; end
      SEG7_7:     begin dec.known = 1'b1; dec.nibble = 4'h7; end
      SEG7_8:     begin dec.known = 1'b1; dec.nibble = 4'h8; end
      SEG7_9:     begin dec.known = 1'b1; dec.nibble = 4'h9; end
`ifdef SEG7_DEC_HEX_EN
      SEG7_HA:    begin dec.known = 1'b1; dec.nibble = 4'hA; end
      SEG7_HB:    begin dec.known = 1'b1; dec.nibble = 4'hB; end
      SEG7_HC:    begin dec.known = 1'b1; dec.nibble = 4'hC; end
      SEG7_HD:    begin dec.known = 1'b1; dec.nibble = 4'hD; end
      SEG7_HE:    begin dec.known = 1'b1; dec.nibble = 4'hE; end
      SEG7_HF:    begin dec.known = 1'b1; dec.nibble = 4'hF; end
`else
      // A-F glyphs are deliberately not decoded in the decimal-only build.
`endif
      default:    dec = '0;
    endcase
  end

  assign known_o    = dec.known;
  assign is_blank_o = dec.is_blank;
  assign nibble_o   = dec.nibble;

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed seven-segment bus, debounces
// each digit and publishes complete decoded frames.
//   Parameters:
//     DIGITS         number of multiplexed digit positions (>=1)
//     STABLE_CYCLES  identical consecutive samples needed to accept a digit
//   Ports:
//     clk            rising-edge clock
//     reset          asynchronous active-high reset
//     seg_in   [6:0] segment word {a,b,c,d,e,f,g}, active-high
//     sel_in   [DIGITS-1:0] one-hot digit select
//     value    [4*DIGITS-1:0] decoded frame, nibble i = digit i
//     blank    [DIGITS-1:0] digit i was all segments off
//     frame_valid    one-cycle strobe when value/blank/pattern_err update
//     pattern_err    last frame held an unrecognised pattern
//   Macro SEG7_DEC_HEX_EN: enables A-F decoding (see seg7_pattern_decode).
//
// Output protocol: frame_valid is a valid-only strobe with no ready; the
// consumer must take value/blank/pattern_err in the cycle it is high. The
// outputs then hold until the next frame completes.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     sel_in,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  pattern_err
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  // Sample registers and run counter
  logic [6:0]          prev_seg_q;
  logic [DIGITS-1:0]   prev_sel_q;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Staging for the frame under construction
  logic [4*DIGITS-1:0] stage_nib_q, stage_nib_d;
  logic [DIGITS-1:0]   stage_blank_q, stage_blank_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                err_q, err_d;

  // Published frame
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                fv_q, fv_d;
  logic                perr_q, perr_d;

  logic                dec_known;
  logic                dec_blank;
  logic [3:0]          dec_nibble;

  logic                sel_onehot;
  logic                same;
  logic                at_max;
  logic                commit;
  logic                commit_err;

  seg7_pattern_decode u_decode (
    .seg_i      (seg_in),
    .known_o    (dec_known),
    .is_blank_o (dec_blank),
    .nibble_o   (dec_nibble)
  );

  assign sel_onehot = (sel_in != '0) &&
                      ((sel_in & (sel_in - DIGITS'(1))) == '0);
  assign same       = (seg_in == prev_seg_q) && (sel_in == prev_sel_q);
  assign at_max     = (cnt_q == CNT_MAX);

  // Run counter: saturates so a long hold commits only once.
  always_comb begin
    cnt_d = '0;
    if (!sel_onehot) begin
      cnt_d = '0;
    end else if (same) begin
      cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = CW'(1);
    end
  end

  // Commit on the edge the counter first reaches the threshold. The
  // saturated case (already at max and still the same input) is excluded;
  // a new run with STABLE_CYCLES = 1 commits even if cnt_q was at max.
  assign commit     = sel_onehot && (cnt_d == CNT_MAX) && !(same && at_max);
  assign commit_err = commit && !dec_known && !dec_blank;

  always_comb begin
    stage_nib_d   = stage_nib_q;
    stage_blank_d = stage_blank_q;
    seen_d        = seen_q;
    err_d         = err_q;
    value_d       = value_q;
    blank_d       = blank_q;
    perr_d        = perr_q;
    fv_d          = 1'b0;
    if (commit) begin
      seen_d = seen_q | sel_in;
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_in[i]) begin
          if (dec_known) begin
            stage_nib_d[4*i +: 4] = dec_nibble;
            stage_blank_d[i]      = 1'b0;
          end else if (dec_blank) begin
            stage_nib_d[4*i +: 4] = 4'h0;
            stage_blank_d[i]      = 1'b1;
          end
          // Unrecognised: slot keeps its previous contents.
        end
      end
      if (&seen_d) begin
        // Publish including the digit committing on this edge.
        value_d = stage_nib_d;
        blank_d = stage_blank_d;
        perr_d  = err_q | commit_err;
        fv_d    = 1'b1;
        seen_d  = '0;
        err_d   = 1'b0;
      end else begin
        err_d = err_q | commit_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_seg_q    <= '0;
      prev_sel_q    <= '0;
      cnt_q         <= '0;
      stage_nib_q   <= '0;
      stage_blank_q <= '0;
      seen_q        <= '0;
      err_q         <= 1'b0;
      value_q       <= '0;
      blank_q       <= '0;
      fv_q          <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      prev_seg_q    <= seg_in;
      prev_sel_q    <= sel_in;
      cnt_q         <= cnt_d;
      stage_nib_q   <= stage_nib_d;
      stage_blank_q <= stage_blank_d;
      seen_q        <= seen_d;
      err_q         <= err_d;
      value_q       <= value_d;
      blank_q       <= blank_d;
      fv_q          <= fv_d;
      perr_q        <= perr_d;
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign pattern_err = perr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random stimulus for seg7_scan_decoder,
// checked against a frame-level reference model built from the glyph table.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   sel_in;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic                frame_valid;
  logic                pattern_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .value       (value),
    .blank       (blank),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  logic [6:0]          pat [16];
  logic [3:0]          m_nib [DIGITS];
  logic [DIGITS-1:0]   m_sblank;
  logic [DIGITS-1:0]   m_seen;
  logic                m_err;
  logic [4*DIGITS-1:0] e_value;
  logic [DIGITS-1:0]   e_blank;
  logic                e_fv;
  logic                e_pe;
  logic [6:0]          last_seg;
  logic [DIGITS-1:0]   last_sel;
  int                  run_len;
  logic [4*DIGITS-1:0] exp_q[$];

  function automatic int glyph_value(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) begin
      if (pat[i] == seg) begin
`ifdef SEG7_DEC_HEX_EN
        return i;
`else
        return (i < 10) ? i : -1;
`endif
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) m_nib[i] = 4'h0;
    m_sblank = '0;
    m_seen   = '0;
    m_err    = 1'b0;
    e_value  = '0;
    e_blank  = '0;
    e_fv     = 1'b0;
    e_pe     = 1'b0;
    last_seg = '0;
    last_sel = '0;
    run_len  = 0;
    exp_q.delete();
  endtask

  // One clock edge as seen by the model: count the length of the current
  // run of identical one-hot samples; the sample completing run length S
  // is the digit accepted.
  task automatic model_edge(input logic [DIGITS-1:0] sel, input logic [6:0] seg);
    bit oh;
    int d;
    int v;
    bit bad;
    oh   = (sel != 0) && ($countones(sel) == 1);
    e_fv = 1'b0;
    if (!oh) run_len = 0;
    else if (sel == last_sel && seg == last_seg) run_len++;
    else run_len = 1;
    last_sel = sel;
    last_seg = seg;
    if (oh && run_len == S) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (sel[i]) d = i;
      v   = glyph_value(seg);
      bad = 1'b0;
      if (seg == 7'b0000000) begin
        m_nib[d] = 4'h0; m_sblank[d] = 1'b1;
      end else if (v >= 0) begin
        m_nib[d] = 4'(v); m_sblank[d] = 1'b0;
      end else begin
        bad = 1'b1;
      end
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        for (int i = 0; i < DIGITS; i++) e_value[4*i +: 4] = m_nib[i];
        e_blank = m_sblank;
        e_pe    = m_err | bad;
        e_fv    = 1'b1;
        m_seen  = '0;
        m_err   = 1'b0;
        exp_q.push_back(e_value);
      end else begin
        m_err = m_err | bad;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("frame_valid", 32'(frame_valid), 32'(e_fv));
    check("pattern_err", 32'(pattern_err), 32'(e_pe));
    check("value", 32'(value), 32'(e_value));
    check("blank", 32'(blank), 32'(e_blank));
    if (frame_valid === 1'b1) begin
      if (exp_q.size() > 0) check("frame_q", 32'(value), 32'(exp_q.pop_front()));
      else check("unexpected_frame", 32'(frame_valid), 32'(0));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      sel_in = sel;
      seg_in = seg;
      @(posedge clk);
      #1;
      model_edge(sel, seg);
      check_outputs();
    end
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b0001, s0, S);
    hold(4'b0010, s1, S);
    hold(4'b0100, s2, S);
    hold(4'b1000, s3, S);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then
  // releases it on a falling edge.
  task automatic reset_mid();
    #2;
    sel_in = '0;
    seg_in = '0;
    reset  = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101;
    pat[3]  = 7'b1111001; pat[4]  = 7'b0110011; pat[5]  = 7'b1011011;
    pat[6]  = 7'b1011111; pat[7]  = 7'b1110000; pat[8]  = 7'b1111111;
    pat[9]  = 7'b1111011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
    pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111;
    pat[15] = 7'b1000111;

    model_reset();
    reset  = 1'b1;
    sel_in = '0;
    seg_in = '0;
    #2;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Nominal frame
    frame(pat[0], pat[1], pat[2], pat[3]);
    check("nom_value", 32'(value), 32'h3210);
    check("nom_blank", 32'(blank), 32'h0);
    check("nom_perr", 32'(pattern_err), 32'h0);

    // Glitch debounce on digit 0, then a 3-cycle burst that must not commit
    hold(4'b0001, pat[1], 3);
    hold(4'b0001, pat[8], 1);
    hold(4'b0001, pat[1], 4);
    hold(4'b0001, pat[8], 3);
    hold(4'b0010, pat[5], S);
    hold(4'b0100, pat[6], S);
    hold(4'b1000, pat[7], S);
    check("glitch_value", 32'(value), 32'h7651);

    // Bad pattern on digit 2 retains the previous nibble
    frame(pat[0], pat[1], pat[2], pat[3]);
    frame(pat[0], pat[1], 7'b1010101, pat[3]);
    check("bad_perr", 32'(pattern_err), 32'h1);
    check("bad_value", 32'(value), 32'h3210);
    frame(pat[0], pat[1], pat[2], pat[3]);
    check("clean_perr", 32'(pattern_err), 32'h0);

    // Blank digit 3, then a multi-hot select held 10 cycles
    frame(pat[0], pat[1], pat[2], 7'b0000000);
    check("blank_blank", 32'(blank), 32'h8);
    check("blank_value", 32'(value), 32'h0210);
    hold(4'b0011, pat[5], 10);
    hold(4'b0000, pat[5], 2);

    // Hex glyph on digit 0
    frame(pat[10], pat[1], pat[2], pat[3]);
`ifdef SEG7_DEC_HEX_EN
    check("hex_value", 32'(value), 32'h321A);
    check("hex_perr", 32'(pattern_err), 32'h0);
`else
    check("hex_value", 32'(value), 32'h3210);
    check("hex_perr", 32'(pattern_err), 32'h1);
`endif

    // Reset mid-frame discards the partial frame
    hold(4'b0001, pat[4], S);
    hold(4'b0010, pat[5], S);
    reset_mid();
    check("rst_value", 32'(value), 32'h0);
    hold(4'b0100, pat[6], S);
    hold(4'b1000, pat[7], S);
    check("rst_no_frame_value", 32'(value), 32'h0);
    hold(4'b0001, pat[8], S);
    hold(4'b0010, pat[9], S);
    check("rst_frame_value", 32'(value), 32'h7698);

    // Random holds: mostly one-hot selects with table glyphs
    for (int t = 0; t < 150; t++) begin
      logic [DIGITS-1:0] rs;
      logic [6:0]        rg;
      int                r;
      r = $urandom_range(0, 9);
      if (r < 8) rs = DIGITS'(1 << $urandom_range(0, DIGITS - 1));
      else rs = DIGITS'($urandom_range(0, (1 << DIGITS) - 1));
      r = $urandom_range(0, 9);
      if (r < 7) rg = pat[$urandom_range(0, 15)];
      else if (r < 8) rg = 7'b0000000;
      else rg = 7'($urandom_range(0, 127));
      hold(rs, rg, $urandom_range(1, 6));
    end
    hold(4'b0000, 7'b0000000, 2);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
